// File: rtl/rbs_pkg.sv
// Shared constants, stage-count helpers and pipeline record for the ripple-borrow subtractor.
package rbs_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned BPS_DEF   = 2;

    function automatic int unsigned calc_nstage(input int unsigned width, input int unsigned bps);
        return width / bps;
    endfunction

    function automatic int unsigned calc_latency(input int unsigned width, input int unsigned bps);
        return calc_nstage(width, bps) + 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 br;
        logic [WIDTH_DEF-1:0] d;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
    } stage_t;

endpackage

// File: rtl/rbs_slice.sv
// Combinational BPS-bit ripple-borrow slice: d = a - b - br_in over the slice.
module rbs_slice #(
    parameter int unsigned BPS = 2
) (
    input  logic [BPS-1:0] a,
    input  logic [BPS-1:0] b,
    input  logic           br_in,
    output logic [BPS-1:0] d,
    output logic           br_out
);

    logic br;

    always_comb begin
        br = br_in;
        d  = '0;
        for (int unsigned i = 0; i < BPS; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        br_out = br;
    end

endmodule

// File: rtl/rbs_pipe_2bit.sv
// Pipelined ripple-borrow subtractor with valid/ready handshake.
// Optional signed-overflow output enabled by defining RBS_OVF_EN.
module rbs_pipe_2bit
    import rbs_pkg::*;
#(
    parameter int unsigned WIDTH          = WIDTH_DEF,
    parameter int unsigned BITS_PER_STAGE = BPS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef RBS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned BPS    = BITS_PER_STAGE;
    localparam int unsigned NSTAGE = calc_nstage(WIDTH, BITS_PER_STAGE);

    if ((WIDTH % BITS_PER_STAGE) != 0) begin : g_bad_cfg
        $error("WIDTH must be a multiple of BITS_PER_STAGE");
    end

    logic             adv;
    logic             v_q  [0:NSTAGE];
    logic             br_q [0:NSTAGE];
    logic [WIDTH-1:0] d_q  [0:NSTAGE];
    logic [WIDTH-1:0] a_q  [0:NSTAGE];
    logic [WIDTH-1:0] b_q  [0:NSTAGE];
    logic [WIDTH-1:0] sd;
    logic [NSTAGE:1]  sbr;
`ifdef RBS_OVF_EN
    logic             ovf_q;
`endif

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_slice
        rbs_slice #(.BPS(BPS)) u_slice (
            .a      (a_q[k-1][(k-1)*BPS +: BPS]),
            .b      (b_q[k-1][(k-1)*BPS +: BPS]),
            .br_in  (br_q[k-1]),
            .d      (sd[(k-1)*BPS +: BPS]),
            .br_out (sbr[k])
        );
    end

    // Resolved operand bits are masked off and diff bits accumulate, so unused flops stay constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= NSTAGE; k++) begin
                v_q[k]  <= 1'b0;
                br_q[k] <= 1'b0;
                d_q[k]  <= '0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
            end
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
`ifdef RBS_OVF_EN
            ovf_q     <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else if (adv) begin
            v_q[0]  <= in_valid;
            br_q[0] <= bin;
            d_q[0]  <= '0;
            a_q[0]  <= a;
            b_q[0]  <= b;
            for (int unsigned k = 1; k <= NSTAGE; k++) begin
                v_q[k]  <= v_q[k-1];
                br_q[k] <= sbr[k];
                d_q[k]  <= d_q[k-1] | (sd & ({WIDTH{1'b1}} << ((k-1)*BPS))
                                           & ~({WIDTH{1'b1}} << (k*BPS)));
                a_q[k]  <= a_q[k-1] & ({WIDTH{1'b1}} << (k*BPS));
                b_q[k]  <= b_q[k-1] & ({WIDTH{1'b1}} << (k*BPS));
            end
            out_valid <= v_q[NSTAGE];
            diff      <= d_q[NSTAGE];
            bout      <= br_q[NSTAGE];
`ifdef RBS_OVF_EN
            ovf_q <= (a_q[NSTAGE-1][WIDTH-1] ^ b_q[NSTAGE-1][WIDTH-1])
                   & (sd[WIDTH-1] ^ a_q[NSTAGE-1][WIDTH-1]);
            ovf   <= ovf_q;
`endif
        end
    end

endmodule

// File: tb/tb_rbs_pipe_2bit.sv
// Scoreboard bench for rbs_pipe_2bit; ovf checks compiled in when RBS_OVF_EN is defined.
module tb_rbs_pipe_2bit;
    import rbs_pkg::*;

    localparam int unsigned LAT = calc_latency(8, 2);

    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       bout;
    logic       out_valid;
    logic       out_ready;
`ifdef RBS_OVF_EN
    logic       ovf;
`endif

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;

    rbs_pipe_2bit #(.WIDTH(8), .BITS_PER_STAGE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RBS_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] r;
        exp_t e;
        r = {1'b0, x} - {1'b0, y} - {8'b0, c};
        e.diff = r[7:0];
        e.bout = r[8];
        e.ovf  = (x[7] ^ y[7]) & (r[7] ^ x[7]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        a = ta; b = tb; bin = tc; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(model(ta, tb, tc));
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", 32'(acc), 32'h1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(sb.size()), 32'h0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(out_valid), 32'h1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                check("sb_diff", 32'(diff), 32'(e.diff));
                check("sb_bout", 32'(bout), 32'(e.bout));
`ifdef RBS_OVF_EN
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        rst_n = 1'b1; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_diff", 32'(diff), 32'h0);
        check("rst_bout", 32'(bout), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Exact latency and single-cycle valid for one beat.
        a = 8'h00; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        sb.push_back(model(8'h00, 8'h01, 1'b0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("lat_edge0", 32'(out_valid), 32'h0);
        for (int i = 1; i < int'(LAT); i++) begin
            @(posedge clk);
            #1;
            check("lat_early", 32'(out_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'h1);
        check("lat_diff", 32'(diff), 32'hFF);
        check("lat_bout", 32'(bout), 32'h1);
        @(posedge clk);
        #1;
        check("lat_one_cycle", 32'(out_valid), 32'h0);
        drain("drain_lat");

        send(8'hA5, 8'h5A, 1'b1);
        send(8'h5A, 8'h5A, 1'b1);
        drain("drain_pair");

        // Back-to-back random stream: results must arrive with no gaps.
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(8'($urandom), 8'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                wait_valid("stream_start");
                for (int j = 0; j < 16; j++) begin
                    check("stream_gap", 32'(out_valid), 32'h1);
                    @(posedge clk);
                    #1;
                end
                check("stream_end", 32'(out_valid), 32'h0);
            end
        join
        drain("drain_stream");
        check("stream_count", 32'(pops - p0), 32'd16);

        // Stall while the first result is presented.
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(8'($urandom), 8'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                wait_valid("stall_seen");
                out_ready = 1'b0;
                #1;
                check("stall_in_ready0", 32'(in_ready), 32'h0);
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk);
                    #1;
                    check("stall_valid", 32'(out_valid), 32'h1);
                    check("stall_diff", 32'(diff), 32'(sb[0].diff));
                    check("stall_bout", 32'(bout), 32'(sb[0].bout));
                    check("stall_in_ready", 32'(in_ready), 32'h0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        check("stall_count", 32'(pops - p0), 32'd8);

`ifdef RBS_OVF_EN
        send(8'h80, 8'h01, 1'b0);
        send(8'h10, 8'h01, 1'b0);
        drain("drain_ovf");
`endif

        // Asynchronous reset with beats in flight.
        for (int i = 0; i < 7; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom));
        in_valid = 1'b0;
        check("rst_mid_pre", 32'(out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'h0);
        check("rst_mid_diff", 32'(diff), 32'h0);
        check("rst_mid_bout", 32'(bout), 32'h0);
        check("rst_mid_in_ready", 32'(in_ready), 32'h1);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_stale", 32'(out_valid), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
